sseg_scan_driver: RTL and testbench
===================================

Name: sseg_scan_driver

Overview:
Downstream display stage fed by the sequence generator. Takes eight hex digits, per-digit decimal points and a digit-enable mask through a load strobe, then time-multiplexes them onto the board's active-low 7-segment cathode/anode pins. Double-buffered so a new value only appears at a frame boundary, which prevents torn frames. Includes a SIM parameter so the scan rate can be shortened for simulation.

Parameters:
SIM, 0, 1 = simulation scan rate: TICKS = 4 clk per digit slot
DIV, 100000, clk cycles per digit slot when SIM=0 (TICKS = DIV); must be >= 2

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
digits  in  32  eight hex nibbles; digit k = digits[4k+3:4k]; digit 0 is rightmost
dp  in  8  decimal-point request per digit, active-high
mask  in  8  digit enable per digit, active-high
load  in  1  single-cycle strobe; captures digits/dp/mask into the pending buffer
busy  out  1  high while a pending update has not yet been applied
frame_tick  out  1  one-cycle pulse on each 7->0 wrap
SSEG_CA  out  8  active-low cathodes: [7]=DP, [6:0]=g..a
SSEG_AN  out  8  active-low anodes; AN[k] selects digit k

Behaviour:
- Reset (reset=0, asynchronous):
  - div counter, digit index, pending buffer and active buffer all cleared (active mask = 0).
  - SSEG_AN=8'hFF, SSEG_CA=8'hFF, busy=0, frame_tick=0.
- Divider counts 0..TICKS-1. At terminal count it returns to 0 and the index advances; index 7 wraps to 0.
- All outputs are registered. Slot k spans TICKS cycles, starting the cycle after the index changes.
- Ghost blanking: in cycle 0 of every slot, SSEG_AN=8'hFF and SSEG_CA=8'hFF.
- Cycles 1..TICKS-1 of the slot:
  - SSEG_AN = ~(8'h01<<k) if active mask[k]=1, otherwise 8'hFF.
  - SSEG_CA[6:0] = decode(nibble k).
  - SSEG_CA[7] = ~dp[k].
- Decode table (CA[6:0], with the DP bit off, shown as a byte): 0=C0 1=F9 2=A4 3=B0 4=99 5=92 6=82 7=F8 8=80 9=90 A=88 b=83 C=C6 d=A1 E=86 F=8E.
- load with busy=0: capture digits/dp/mask into pending; busy=1 on the next cycle.
- load with busy=1: pending is overwritten (last load wins); busy stays 1.
- Frame boundary (terminal count while index=7):
  - If busy=1: pending is copied to active and busy is cleared in the same edge.
  - frame_tick pulses on that edge; the next slot (digit 0) uses the new data.
- load coincident with the frame boundary:
  - Any older pending data is applied.
  - The new load is captured into pending and busy remains/becomes 1.
  - The new data is applied at the following frame.
- Reset mid-frame: outputs go to FF immediately, without waiting for a clock edge. After release, scanning restarts at digit 0, cycle 0, with the active mask at 0 (all blank) until a load is applied.
- Frame length = 8*TICKS cycles (32 when SIM=1).

Optional Feature:
SSEG_LZB_EN
- Defined: leading-zero blanking. A digit k>0 is blanked (AN[k]=1) when it and every higher digit have nibble=0 and dp=0. Digit 0 is never blanked by this rule. Evaluated on the active buffer.
- Not defined: every digit whose active mask bit is set is displayed, zeros included.

Test Plan:
- Reset: hold reset=0 for 3 clk -> SSEG_AN=FF, SSEG_CA=FF, busy=0. Release with no load, SIM=1 -> AN stays FF for 64 cycles; frame_tick every 32 cycles.
- Load: digits=32'h76543210, dp=0, mask=FF -> busy=1 until the next wrap, where frame_tick=1 and busy=0. Then per 4-cycle slot: cycle 0 AN=FF; cycles 1-3 show digit 0 AN=FE CA=C0, digit 3 AN=F7 CA=B0, digit 7 AN=7F CA=F8.
- Two loads within one frame (32'h11111111 then 32'hFFFFFFFF) -> the following frame shows only CA=8E on all digits; CA=F9 never appears.
- mask=8'h0F -> AN[7:4]=1 for the entire frame; AN[3:0] scan as normal.
- digits nibble 0 = 8, dp=8'h01 -> digit 0 slot CA=00; other digits have CA[7]=1.
- Reset asserted mid-slot at digit 5 -> AN=FF immediately. After release, the first non-blank slot is digit 0, and only after a new load is applied.
- With SSEG_LZB_EN, digits=32'h00000050, mask=FF -> AN[7:2]=1 all frame; digit 1 CA=92; digit 0 CA=C0.

Source files
------------

// File: rtl/sseg_scan_driver_if.sv
// Load-side bus of the 7-segment scan driver: eight hex digits, decimal points,
// digit-enable mask, a single-cycle load strobe, and the busy flag returned by the driver.
interface sseg_scan_driver_if;
  logic [31:0] digits;
  logic [7:0]  dp;
  logic [7:0]  mask;
  logic        load;
  logic        busy;

  modport master (output digits, output dp, output mask, output load, input busy);
  modport slave  (input digits, input dp, input mask, input load, output busy);
endinterface

// File: rtl/sseg_scan_driver.sv
// Double-buffered, time-multiplexed driver for an 8-digit active-low 7-segment display.
// Optional macro SSEG_LZB_EN enables leading-zero blanking on the active buffer.
module sseg_scan_driver #(
  parameter int SIM = 0,
  parameter int DIV = 100000
) (
  input  logic                 clk,
  input  logic                 reset,
  sseg_scan_driver_if.slave    bus,
  output logic                 frame_tick,
  output logic [7:0]           SSEG_CA,
  output logic [7:0]           SSEG_AN
);

  localparam int TICKS = (SIM != 0) ? 4 : DIV;
  localparam int CW    = (TICKS > 1) ? $clog2(TICKS) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICKS - 1);

  logic [CW-1:0] div_reg, div_next;
  logic [2:0]    idx_reg, idx_next;
  logic [31:0]   pend_digits_reg, pend_digits_next;
  logic [7:0]    pend_dp_reg, pend_dp_next;
  logic [7:0]    pend_mask_reg, pend_mask_next;
  logic [31:0]   act_digits_reg, act_digits_next;
  logic [7:0]    act_dp_reg, act_dp_next;
  logic [7:0]    act_mask_reg, act_mask_next;
  logic          busy_reg, busy_next;
  logic          frame_tick_reg;
  logic [7:0]    an_reg, an_next;
  logic [7:0]    ca_reg, ca_next;
  logic          terminal, boundary, apply;
  logic [3:0]    nib;
  logic          show;
  logic [7:0]    blank_lz;

  function automatic logic [6:0] seg7(input logic [3:0] n);
    case (n)
      4'h0: seg7 = 7'h40;
      4'h1: seg7 = 7'h79;
      4'h2: seg7 = 7'h24;
      4'h3: seg7 = 7'h30;
      4'h4: seg7 = 7'h19;
      4'h5: seg7 = 7'h12;
      4'h6: seg7 = 7'h02;
      4'h7: seg7 = 7'h78;
      4'h8: seg7 = 7'h00;
      4'h9: seg7 = 7'h10;
      4'hA: seg7 = 7'h08;
      4'hB: seg7 = 7'h03;
      4'hC: seg7 = 7'h46;
      4'hD: seg7 = 7'h21;
      4'hE: seg7 = 7'h06;
      default: seg7 = 7'h0E;
    endcase
  endfunction

  // Scan timing and buffer management; a load on the frame edge lands in pending
  // after the older pending value has been promoted.
  always_comb begin
    terminal = (div_reg == LAST);
    boundary = terminal && (idx_reg == 3'd7);
    apply    = boundary && busy_reg;

    div_next = terminal ? '0 : div_reg + 1'b1;
    idx_next = terminal ? idx_reg + 3'd1 : idx_reg;

    act_digits_next = apply ? pend_digits_reg : act_digits_reg;
    act_dp_next     = apply ? pend_dp_reg     : act_dp_reg;
    act_mask_next   = apply ? pend_mask_reg   : act_mask_reg;

    pend_digits_next = bus.load ? bus.digits : pend_digits_reg;
    pend_dp_next     = bus.load ? bus.dp     : pend_dp_reg;
    pend_mask_next   = bus.load ? bus.mask   : pend_mask_reg;

    busy_next = bus.load ? 1'b1 : (apply ? 1'b0 : busy_reg);
  end

`ifdef SSEG_LZB_EN
  logic [7:0] digit_zero;
  logic       run_zero;

  for (genvar gi = 0; gi < 8; gi++) begin : g_zero
    assign digit_zero[gi] = (act_digits_next[4*gi +: 4] == 4'h0) && !act_dp_next[gi];
  end

  // A digit is a leading zero only if it and everything above it is blank.
  always_comb begin
    run_zero = 1'b1;
    blank_lz = '0;
    for (int i = 7; i >= 1; i--) begin
      run_zero    = run_zero & digit_zero[i];
      blank_lz[i] = run_zero;
    end
  end
`else
  assign blank_lz = '0;
`endif

  // Outputs are computed from the next state so the registered pins line up with the slot.
  always_comb begin
    nib     = act_digits_next[{idx_next, 2'b00} +: 4];
    show    = act_mask_next[idx_next] & ~blank_lz[idx_next];
    an_next = 8'hFF;
    ca_next = 8'hFF;
    if (div_next != '0) begin
      if (show) begin
        an_next = ~(8'h01 << idx_next);
      end
      ca_next = {~act_dp_next[idx_next], seg7(nib)};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_reg         <= '0;
      idx_reg         <= '0;
      pend_digits_reg <= '0;
      pend_dp_reg     <= '0;
      pend_mask_reg   <= '0;
      act_digits_reg  <= '0;
      act_dp_reg      <= '0;
      act_mask_reg    <= '0;
      busy_reg        <= 1'b0;
      frame_tick_reg  <= 1'b0;
      an_reg          <= 8'hFF;
      ca_reg          <= 8'hFF;
    end else begin
      div_reg         <= div_next;
      idx_reg         <= idx_next;
      pend_digits_reg <= pend_digits_next;
      pend_dp_reg     <= pend_dp_next;
      pend_mask_reg   <= pend_mask_next;
      act_digits_reg  <= act_digits_next;
      act_dp_reg      <= act_dp_next;
      act_mask_reg    <= act_mask_next;
      busy_reg        <= busy_next;
      frame_tick_reg  <= boundary;
      an_reg          <= an_next;
      ca_reg          <= ca_next;
    end
  end

  assign bus.busy   = busy_reg;
  assign frame_tick = frame_tick_reg;
  assign SSEG_AN    = an_reg;
  assign SSEG_CA    = ca_reg;

endmodule

// File: tb/tb_sseg_scan_driver.sv
// Self-checking bench for sseg_scan_driver (SIM=1): constant vector table, corner
// sequences, and randomized loads checked every cycle against a timeline model.
module tb_sseg_scan_driver;

  logic       clk = 1'b0;
  logic       reset;
  logic       frame_tick;
  logic [7:0] SSEG_CA;
  logic [7:0] SSEG_AN;

  sseg_scan_driver_if bus ();

  sseg_scan_driver #(.SIM(1), .DIV(100000)) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus.slave),
    .frame_tick (frame_tick),
    .SSEG_CA    (SSEG_CA),
    .SSEG_AN    (SSEG_AN)
  );

  always #5 clk = ~clk;

  localparam logic [7:0] SEG_TAB [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                          8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  typedef struct {
    int          cl;
    logic [31:0] d;
    logic [7:0]  dp;
    logic [7:0]  m;
  } load_t;

  typedef struct {
    logic [31:0] d;
    logic [7:0]  dp;
    logic [7:0]  m;
    int          k;
    logic [7:0]  an;
    logic [7:0]  ca;
  } vec_t;

  load_t loads[$];
  vec_t  vt[12];
  int    n_checks = 0;
  int    n_fail   = 0;
  int    cyc      = 0;

  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%h expected=%h", name, cyc, got, exp);
    end
  endtask

  // Frame f shows the last load made at least two cycles before the frame starts;
  // busy spans from the cycle after a load to the frame that first shows it.
  function automatic void model(input int c, output logic [7:0] an, output logic [7:0] ca,
                                output logic busy, output logic ft);
    logic [31:0] d;
    logic [7:0]  p, m;
    logic [3:0]  nib;
    logic        show;
    int          k, ph;
    d = '0; p = '0; m = '0; busy = 1'b0;
    foreach (loads[i]) begin
      if ((loads[i].cl + 1) / 32 <= c / 32 - 1) begin
        d = loads[i].d; p = loads[i].dp; m = loads[i].m;
      end
      if (loads[i].cl <= c - 1 && c / 32 == (loads[i].cl + 1) / 32) busy = 1'b1;
    end
    ft = (c > 0) && (c % 32 == 0);
    k  = (c / 4) % 8;
    ph = c % 4;
    an = 8'hFF;
    ca = 8'hFF;
    if (ph != 0) begin
      show = m[k];
`ifdef SSEG_LZB_EN
      if (k > 0 && (d >> (4 * k)) == 32'd0 && (p >> k) == 8'd0) show = 1'b0;
`endif
      if (show) an = ~(8'h01 << k);
      nib = 4'((d >> (4 * k)) & 32'hF);
      ca  = {~p[k], SEG_TAB[nib][6:0]};
    end
  endfunction

  task automatic step(input bit ld, input logic [31:0] d, input logic [7:0] p, input logic [7:0] m);
    logic [7:0] e_an, e_ca;
    logic       e_busy, e_ft;
    model(cyc, e_an, e_ca, e_busy, e_ft);
    chk("model_an", SSEG_AN, e_an);
    chk("model_ca", SSEG_CA, e_ca);
    chk("model_busy", {7'd0, bus.busy}, {7'd0, e_busy});
    chk("model_frame_tick", {7'd0, frame_tick}, {7'd0, e_ft});
    if (ld) begin
      loads.push_back('{cl: cyc, d: d, dp: p, m: m});
      bus.digits = d; bus.dp = p; bus.mask = m; bus.load = 1'b1;
      $display("load cyc=%0d digits=%h dp=%h mask=%h", cyc, d, p, m);
    end else begin
      bus.load = 1'b0;
    end
    @(negedge clk);
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, '0, '0);
  endtask

  task automatic align(input int pos);
    while (cyc % 32 != pos) step(1'b0, '0, '0, '0);
  endtask

  task automatic wait_applied();
    int w = 0;
    while (bus.busy !== 1'b0 && w < 100) begin
      step(1'b0, '0, '0, '0);
      w++;
    end
    n_checks++;
    if (w >= 100) begin
      n_fail++;
      $display("FAIL busy_clear_timeout cyc=%0d got busy=%b expected 0 within 100 cycles", cyc, bus.busy);
    end
  endtask

  task automatic do_reset(input bit mid);
    if (mid) begin
      #2 reset = 1'b0;
      #1;
      chk("async_reset_an", SSEG_AN, 8'hFF);
      chk("async_reset_ca", SSEG_CA, 8'hFF);
    end else begin
      reset = 1'b0;
    end
    bus.load = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_an", SSEG_AN, 8'hFF);
    chk("reset_ca", SSEG_CA, 8'hFF);
    chk("reset_busy", {7'd0, bus.busy}, 8'h00);
    chk("reset_frame_tick", {7'd0, frame_tick}, 8'h00);
    reset = 1'b1;
    loads.delete();
    cyc = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog cyc=%0d simulation did not finish in time", cyc);
    $fatal(1);
  end

  initial begin
    vt[0]  = '{32'h76543210, 8'h00, 8'hFF, 0, 8'hFE, 8'hC0};
    vt[1]  = '{32'h76543210, 8'h00, 8'hFF, 3, 8'hF7, 8'hB0};
    vt[2]  = '{32'h76543210, 8'h00, 8'hFF, 7, 8'h7F, 8'hF8};
    vt[3]  = '{32'h76543218, 8'h01, 8'hFF, 0, 8'hFE, 8'h00};
    vt[4]  = '{32'h76543218, 8'h01, 8'hFF, 1, 8'hFD, 8'hF9};
    vt[5]  = '{32'h76543210, 8'h00, 8'h0F, 5, 8'hFF, 8'h92};
    vt[6]  = '{32'h76543210, 8'h00, 8'h0F, 2, 8'hFB, 8'hA4};
    vt[7]  = '{32'hFEDCBA98, 8'h80, 8'hFF, 7, 8'h7F, 8'h0E};
    vt[8]  = '{32'hFEDCBA98, 8'h80, 8'hFF, 4, 8'hEF, 8'hC6};
    vt[9]  = '{32'h00000098, 8'h00, 8'hFF, 1, 8'hFD, 8'h90};
    vt[10] = '{32'hFEDCBA98, 8'h80, 8'hFF, 2, 8'hFB, 8'h88};
    vt[11] = '{32'hFEDCBA98, 8'h80, 8'hFF, 6, 8'hBF, 8'h86};

    bus.load = 1'b0; bus.digits = '0; bus.dp = '0; bus.mask = '0;
    @(negedge clk);
    do_reset(1'b0);

    // Blank after reset: two full frames with no load.
    idle(64);

    // Vector table: load, wait for the frame that applies it, probe slot k.
    for (int v = 0; v < 12; v++) begin
      step(1'b1, vt[v].d, vt[v].dp, vt[v].m);
      wait_applied();
      chk("frame_start_tick", {7'd0, frame_tick}, 8'h01);
      idle(4 * vt[v].k + 1);
      chk($sformatf("vec%0d_an_c1", v), SSEG_AN, vt[v].an);
      chk($sformatf("vec%0d_ca_c1", v), SSEG_CA, vt[v].ca);
      idle(2);
      chk($sformatf("vec%0d_an_c3", v), SSEG_AN, vt[v].an);
      chk($sformatf("vec%0d_ca_c3", v), SSEG_CA, vt[v].ca);
    end

    // Two loads in one frame: only the last is ever shown.
    align(2);
    step(1'b1, 32'h11111111, 8'h00, 8'hFF);
    idle(5);
    step(1'b1, 32'hFFFFFFFF, 8'h00, 8'hFF);
    wait_applied();
    for (int i = 0; i < 32; i++) begin
      if (cyc % 4 != 0) chk("two_load_ca", SSEG_CA, 8'h8E);
      step(1'b0, '0, '0, '0);
    end

    // Load on the frame edge while older data is pending.
    align(20);
    step(1'b1, 32'h00000003, 8'h00, 8'h01);
    align(31);
    step(1'b1, 32'h00000005, 8'h00, 8'h01);
    chk("coincident_busy", {7'd0, bus.busy}, 8'h01);
    step(1'b0, '0, '0, '0);
    chk("coincident_old_an", SSEG_AN, 8'hFE);
    chk("coincident_old_ca", SSEG_CA, 8'hB0);
    wait_applied();
    step(1'b0, '0, '0, '0);
    chk("coincident_new_ca", SSEG_CA, 8'h92);

`ifdef SSEG_LZB_EN
    step(1'b1, 32'h00000050, 8'h00, 8'hFF);
    wait_applied();
    for (int i = 0; i < 32; i++) begin
      chk("lzb_high_blank", {SSEG_AN[7:2], 2'b00}, 8'hFC);
      if (cyc % 32 == 5) chk("lzb_digit1_ca", SSEG_CA, 8'h92);
      if (cyc % 32 == 1) chk("lzb_digit0_ca", SSEG_CA, 8'hC0);
      step(1'b0, '0, '0, '0);
    end
`endif

    // Reset in the middle of digit 5; display stays blank until a new load lands.
    step(1'b1, 32'h76543210, 8'h00, 8'hFF);
    wait_applied();
    align(22);
    chk("pre_reset_an", SSEG_AN, 8'hDF);
    do_reset(1'b1);
    idle(64);
    step(1'b1, 32'h76543210, 8'h00, 8'hFF);
    wait_applied();
    step(1'b0, '0, '0, '0);
    chk("post_reset_first_an", SSEG_AN, 8'hFE);

    // Randomized loads against the timeline model.
    for (int i = 0; i < 1200; i++) begin
      if ($urandom_range(0, 19) == 0) begin
        step(1'b1, $urandom >> ($urandom_range(0, 8) * 4),
             ($urandom_range(0, 1) != 0) ? 8'h00 : 8'($urandom),
             8'($urandom));
      end else begin
        step(1'b0, '0, '0, '0);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
